// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the fetch stage (IF, instruction
// requester) and the memory stage (DM, data requester). One transaction is in
// flight at a time: IDLE arbitrates and latches, ISSUE presents the request to
// memory, RESP waits for the memory response and forwards it to the owner.
//
// Data requests normally win. A burst counter forces a fetch grant after
// MAX_DATA_BURST consecutive contested data grants. A fetch flush while IF
// owns the port marks the response stale; it is consumed from memory but
// never strobed to the fetch stage.
//
// Handshake: a request transfers in a cycle where *_req_valid and
// *_req_ready are both high (requester side), or where mem_req_valid and
// mem_req_ready are both high (memory side). Responses are single-cycle
// strobes with no back-pressure.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   if_req_*           fetch request (valid/addr in, ready out)
//   if_flush           discard the outstanding fetch response
//   if_rsp_valid/data  fetch response strobe and instruction word
//   dm_req_*           data request (valid/addr/we/be/wdata in, ready out)
//   dm_rsp_valid/data  data response strobe; load data, 0 for stores
//   mem_req_*          latched request to memory (ready in)
//   mem_rsp_valid/data memory response strobe and read data
//   state_dbg          current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   input  logic                if_flush,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,

   input  logic                dm_req_valid,
   input  logic [ADDR_W-1:0]   dm_req_addr,
   input  logic                dm_req_we,
   input  logic [DATA_W/8-1:0] dm_req_be,
   input  logic [DATA_W-1:0]   dm_req_wdata,
   output logic                dm_req_ready,
   output logic                dm_rsp_valid,
   output logic [DATA_W-1:0]   dm_rsp_data,

   output logic                mem_req_valid,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_we,
   output logic [DATA_W/8-1:0] mem_req_be,
   output logic [DATA_W-1:0]   mem_req_wdata,
   input  logic                mem_req_ready,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,

   output logic [1:0]          state_dbg
);

   localparam int BC_W = $clog2(MAX_DATA_BURST + 1);
   localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_DATA_BURST);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t          state;
   logic [BC_W-1:0] burst_cnt;
   logic            owner_if;
   logic            drop;
   logic            burst_full;
   logic            grant_if;
   logic            grant_dm;

   assign burst_full = (burst_cnt == BURST_MAX);

   // Grants are combinational so a requester is accepted in the same cycle
   // it is seen in IDLE. Gating with rst keeps both readys low during reset.
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (rst && (state == S_IDLE)) begin
         if (dm_req_valid && (!if_req_valid || !burst_full)) begin
            grant_dm = 1'b1;
         end else if (if_req_valid) begin
            grant_if = 1'b1;
         end
      end
   end

   assign if_req_ready = grant_if;
   assign dm_req_ready = grant_dm;
   assign state_dbg    = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         burst_cnt     <= '0;
         owner_if      <= 1'b0;
         drop          <= 1'b0;
         if_rsp_valid  <= 1'b0;
         if_rsp_data   <= '0;
         dm_rsp_valid  <= 1'b0;
         dm_rsp_data   <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_we    <= 1'b0;
         mem_req_be    <= '0;
         mem_req_wdata <= '0;
      end else begin
         // Response strobes are single-cycle pulses.
         if_rsp_valid <= 1'b0;
         dm_rsp_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_dm) begin
                  mem_req_addr  <= dm_req_addr;
                  mem_req_we    <= dm_req_we;
                  mem_req_be    <= dm_req_be;
                  mem_req_wdata <= dm_req_wdata;
                  owner_if      <= 1'b0;
                  drop          <= 1'b0;
                  mem_req_valid <= 1'b1;
                  state         <= S_ISSUE;
                  // Only data grants that beat a waiting fetch count toward
                  // the burst limit.
                  if (if_req_valid) begin
                     if (!burst_full) begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                     end
                  end else begin
                     burst_cnt <= '0;
                  end
               end else if (grant_if) begin
                  mem_req_addr  <= if_req_addr;
                  mem_req_we    <= 1'b0;
                  mem_req_be    <= '0;
                  mem_req_wdata <= '0;
                  owner_if      <= 1'b1;
                  // A flush coinciding with the grant still issues the fetch
                  // but marks its response stale.
                  drop          <= if_flush;
                  mem_req_valid <= 1'b1;
                  state         <= S_ISSUE;
                  burst_cnt     <= '0;
               end else if (!if_req_valid) begin
                  burst_cnt <= '0;
               end
            end

            S_ISSUE: begin
               if (owner_if && if_flush) begin
                  drop <= 1'b1;
               end
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= S_RESP;
               end
            end

            S_RESP: begin
               if (owner_if && if_flush) begin
                  drop <= 1'b1;
               end
               if (mem_rsp_valid) begin
                  state <= S_IDLE;
                  drop  <= 1'b0;
                  if (owner_if) begin
                     // A flush on the response edge itself also suppresses it.
                     if (!drop && !if_flush) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= mem_rsp_data;
                     end
                  end else begin
                     dm_rsp_valid <= 1'b1;
                     dm_rsp_data  <= mem_req_we ? '0 : mem_rsp_data;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A transaction-level reference model predicts grants,
// memory-side request fields and response strobes; expected response data is
// pushed at grant time and popped by a separate response monitor. A bench
// memory model answers memory requests with configurable or random latency.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXB = 4;

   // ---------------------------------------------------------------- clock/reset
   logic clk;
   logic rst;
   int unsigned cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUT
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_flush;
   logic          if_rsp_valid;
   logic [DW-1:0] if_rsp_data;
   logic          dm_req_valid;
   logic [AW-1:0] dm_req_addr;
   logic          dm_req_we;
   logic [BW-1:0] dm_req_be;
   logic [DW-1:0] dm_req_wdata;
   logic          dm_req_ready;
   logic          dm_rsp_valid;
   logic [DW-1:0] dm_rsp_data;
   logic          mem_req_valid;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_we;
   logic [BW-1:0] mem_req_be;
   logic [DW-1:0] mem_req_wdata;
   logic          mem_req_ready;
   logic          mem_rsp_valid;
   logic [DW-1:0] mem_rsp_data;
   logic [1:0]    state_dbg;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAXB)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we),
      .dm_req_be(dm_req_be), .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
      .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .state_dbg(state_dbg)
   );

   // ---------------------------------------------------------------- shared state
   int n_cmp;
   int n_err;

   logic [DW-1:0] exp_if_q[$];
   logic [DW-1:0] exp_dm_q[$];

   logic [DW-1:0] mem_arr[16];   // contents held by the bench memory
   logic [DW-1:0] ref_mem[16];   // contents predicted by the reference model

   bit cfg_rand;
   int cfg_req_lat;
   int cfg_rsp_lat;
   bit mem_hold;
   bit stim_auto;
   int p_if;
   int p_dm;
   int p_flush;

   int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                              input logic [BW-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < BW; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- bench memory
   initial begin
      int seen;
      int req_lat;
      int rsp_cnt;
      bit lat_set;
      bit m_busy;
      logic [DW-1:0] rdata;
      int idx;
      seen = 0; req_lat = 0; rsp_cnt = 0; lat_set = 0; m_busy = 0; rdata = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_busy  = 0;
            seen    = 0;
            lat_set = 0;
         end else begin
            if (mem_rsp_valid) m_busy = 0;
            if (mem_req_valid && mem_req_ready) begin
               idx = int'(mem_req_addr[5:2]);
               if (mem_req_we) begin
                  mem_arr[idx] = apply_be(mem_arr[idx], mem_req_wdata, mem_req_be);
                  rdata = $urandom;   // stores return junk; the arbiter must zero it
               end else begin
                  rdata = mem_arr[idx];
               end
               m_busy  = 1;
               lat_set = 0;
               seen    = 0;
               rsp_cnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_rsp_lat;
            end else if (mem_req_valid) begin
               seen++;
            end
         end
         @(posedge clk);
         #1;
         if (!mem_hold) begin
            if (mem_req_valid && !lat_set) begin
               req_lat = cfg_rand ? int'($urandom_range(0, 3)) : cfg_req_lat;
               lat_set = 1;
               seen    = 0;
            end
            mem_req_ready = mem_req_valid && (seen >= req_lat);
            if (m_busy && rsp_cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = rdata;
            end else begin
               if (m_busy) rsp_cnt--;
               mem_rsp_valid = 1'b0;
               mem_rsp_data  = $urandom;
            end
         end
      end
   end

   // ---------------------------------------------------------------- random requester driver
   initial begin
      bit if_acc;
      bit dm_acc;
      forever begin
         @(negedge clk);
         if_acc = if_req_valid && if_req_ready;
         dm_acc = dm_req_valid && dm_req_ready;
         @(posedge clk);
         #1;
         if (stim_auto) begin
            if (!if_req_valid || if_acc) begin
               if_req_valid = ($urandom_range(0, 99) < p_if);
               if_req_addr  = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dm_req_valid || dm_acc) begin
               dm_req_valid = ($urandom_range(0, 99) < p_dm);
               dm_req_addr  = 32'($urandom_range(0, 15)) << 2;
               dm_req_we    = 1'($urandom_range(0, 1));
               dm_req_be    = 4'($urandom_range(1, 15));
               dm_req_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 99) < p_flush);
         end
      end
   end

   // ---------------------------------------------------------------- reference model
   // phase: 0 idle, 1 request at memory, 2 waiting for memory response
   initial begin
      int phase;
      int burst;
      bit own_if;
      bit drop;
      bit exp_ifv;
      bit exp_dmv;
      bit iw;
      bit dw;
      int idx;
      logic [AW-1:0] c_addr;
      logic          c_we;
      logic [BW-1:0] c_be;
      logic [DW-1:0] c_wdata;
      phase = 0; burst = 0; own_if = 0; drop = 0; exp_ifv = 0; exp_dmv = 0;
      c_addr = '0; c_we = 0; c_be = '0; c_wdata = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("reset_outputs_zero",
                  |{if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, if_rsp_data,
                    dm_rsp_data, mem_req_valid, mem_req_addr, mem_req_we, mem_req_be,
                    mem_req_wdata}, 1'b0);
            phase = 0; burst = 0; own_if = 0; drop = 0; exp_ifv = 0; exp_dmv = 0;
            exp_if_q.delete();
            exp_dm_q.delete();
         end else begin
            check("if_rsp_valid", if_rsp_valid, exp_ifv);
            check("dm_rsp_valid", dm_rsp_valid, exp_dmv);
            exp_ifv = 0;
            exp_dmv = 0;
            check("mem_req_valid", mem_req_valid, (phase == 1));
            if (phase == 1) begin
               check("mem_req_addr", mem_req_addr, c_addr);
               check("mem_req_we", mem_req_we, c_we);
               check("mem_req_be", mem_req_be, c_be);
               if (!own_if) check("mem_req_wdata", mem_req_wdata, c_wdata);
            end
            iw = 0;
            dw = 0;
            if (phase == 0) begin
               dw = dm_req_valid && (!if_req_valid || burst < MAXB);
               iw = if_req_valid && !dw;
            end
            check("req_ready_pair", {if_req_ready, dm_req_ready}, {iw, dw});
            if (phase != 0 && own_if && if_flush) drop = 1;
            case (phase)
               0: begin
                  if (iw) begin
                     own_if = 1;
                     drop   = if_flush;
                     c_addr = if_req_addr; c_we = 0; c_be = '0; c_wdata = '0;
                     exp_if_q.push_back(ref_mem[int'(if_req_addr[5:2])]);
                     burst  = 0;
                     phase  = 1;
                  end else if (dw) begin
                     own_if  = 0;
                     drop    = 0;
                     c_addr  = dm_req_addr; c_we = dm_req_we; c_be = dm_req_be;
                     c_wdata = dm_req_wdata;
                     idx     = int'(dm_req_addr[5:2]);
                     if (dm_req_we) begin
                        ref_mem[idx] = apply_be(ref_mem[idx], dm_req_wdata, dm_req_be);
                        exp_dm_q.push_back('0);
                     end else begin
                        exp_dm_q.push_back(ref_mem[idx]);
                     end
                     if (if_req_valid) burst = (burst < MAXB) ? burst + 1 : burst;
                     else burst = 0;
                     phase = 1;
                  end else if (!if_req_valid) begin
                     burst = 0;
                  end
               end
               1: if (mem_req_ready) phase = 2;
               2: begin
                  if (mem_rsp_valid) begin
                     if (own_if) begin
                        if (drop) void'(exp_if_q.pop_back());
                        else exp_ifv = 1;
                     end else begin
                        exp_dmv = 1;
                     end
                     phase = 0;
                  end
               end
               default: phase = 0;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (if_rsp_valid) begin
               if (exp_if_q.size() == 0) check("if_rsp_unexpected", if_rsp_valid, 1'b0);
               else check("if_rsp_data", if_rsp_data, exp_if_q.pop_front());
            end
            if (dm_rsp_valid) begin
               if (exp_dm_q.size() == 0) check("dm_rsp_unexpected", dm_rsp_valid, 1'b0);
               else check("dm_rsp_data", dm_rsp_data, exp_dm_q.pop_front());
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic wait_grant(input bit is_if, output int unsigned gcyc);
      bit ok;
      ok   = 0;
      gcyc = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (is_if ? if_req_ready : dm_req_ready) begin
            ok   = 1;
            gcyc = cyc;
            break;
         end
      end
      check(is_if ? "if_grant_seen" : "dm_grant_seen", ok, 1'b1);
      tick();
   endtask

   task automatic count_strobes(input int ncyc, output int n_if, output int n_dm,
                                output logic [DW-1:0] last_if, output logic [DW-1:0] last_dm);
      n_if = 0; n_dm = 0; last_if = '0; last_dm = '0;
      repeat (ncyc) begin
         @(negedge clk);
         if (if_rsp_valid) begin n_if++; last_if = if_rsp_data; end
         if (dm_rsp_valid) begin n_dm++; last_dm = dm_rsp_data; end
      end
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- main sequence
   initial begin
      int unsigned g;
      int n_if;
      int n_dm;
      int n_iss;
      bit found;
      logic [DW-1:0] d_if;
      logic [DW-1:0] d_dm;
      int order[$];

      n_cmp = 0; n_err = 0;
      cfg_rand = 0; cfg_req_lat = 0; cfg_rsp_lat = 0; mem_hold = 0; stim_auto = 0;
      p_if = 60; p_dm = 60; p_flush = 10;
      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = 32'hC0DE_0000 | (32'(i) << 2);
         ref_mem[i] = {16'hC0DE, 16'(i * 4)};
      end
      mem_arr[4] = 32'h0000_0013;
      ref_mem[4] = 32'h0000_0013;

      // Reset with both requesters asking.
      rst = 1'b0;
      if_flush = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 32'h0000_0020;
      dm_req_valid = 1'b1; dm_req_addr = 32'h0000_0000; dm_req_we = 1'b0;
      dm_req_be = 4'hF; dm_req_wdata = 32'h0;
      @(posedge clk);
      @(negedge clk);
      check("reset_ready_pair", {if_req_ready, dm_req_ready}, 2'b00);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("first_idle_dm_ready", dm_req_ready, 1'b1);
      check("first_idle_if_ready", if_req_ready, 1'b0);
      tick();
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      repeat (8) tick();

      // Single zero-wait fetch.
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0010;
      wait_grant(1'b1, g);
      if_req_valid = 1'b0;
      @(negedge clk);
      check("fetch_mem_req_valid", mem_req_valid, 1'b1);
      check("fetch_mem_req_addr", mem_req_addr, 32'h0000_0010);
      check("fetch_mem_req_we", mem_req_we, 1'b0);
      found = 0;
      for (int k = 0; k < 10; k++) begin
         if (if_rsp_valid) begin
            found = 1;
            check("fetch_latency", cyc - g, 3);
            check("fetch_data", if_rsp_data, 32'h0000_0013);
            break;
         end
         @(negedge clk);
      end
      check("fetch_rsp_seen", found, 1'b1);
      repeat (4) tick();

      // Store with memory ready delayed by 3 cycles.
      cfg_req_lat = 3;
      dm_req_valid = 1'b1; dm_req_addr = 32'h0000_0100; dm_req_we = 1'b1;
      dm_req_be = 4'b0011; dm_req_wdata = 32'hDEAD_BEEF;
      wait_grant(1'b0, g);
      dm_req_valid = 1'b0;
      n_iss = 0; n_dm = 0; d_dm = 32'hFFFF_FFFF;
      repeat (15) begin
         @(negedge clk);
         if (mem_req_valid) n_iss++;
         if (dm_rsp_valid) begin n_dm++; d_dm = dm_rsp_data; end
      end
      check("store_issue_cycles", n_iss, 4);
      check("store_rsp_count", n_dm, 1);
      check("store_rsp_data", d_dm, 32'h0);
      cfg_req_lat = 0;
      tick();

      // Contention: both requesters valid continuously.
      if_req_valid = 1'b1; if_req_addr = 32'h0000_0020;
      dm_req_valid = 1'b1; dm_req_addr = 32'h0000_0040; dm_req_we = 1'b0;
      dm_req_be = 4'hF; dm_req_wdata = 32'h0000_1234;
      for (int k = 0; k < 100 && order.size() < 10; k++) begin
         @(negedge clk);
         if (if_req_ready) order.push_back(1);
         else if (dm_req_ready) order.push_back(2);
      end
      tick();
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      check("grant_count", order.size(), 10);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("grant_order[%0d]", k), (k < order.size()) ? order[k] : 0, exp_order[k]);
      end
      repeat (6) tick();

      // Flush while IF waits in RESP; memory answers two cycles later.
      cfg_rsp_lat = 2;
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0018;
      wait_grant(1'b1, g);
      if_req_valid = 1'b0;
      found = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (mem_req_valid && mem_req_ready) begin found = 1; break; end
      end
      check("flush_issue_seen", found, 1'b1);
      tick();
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      count_strobes(8, n_if, n_dm, d_if, d_dm);
      check("flush_if_rsp_count", n_if, 0);
      check("flush_state_idle", state_dbg, 2'd0);
      cfg_rsp_lat = 0;
      tick();
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0000_0018;
      wait_grant(1'b1, g);
      if_req_valid = 1'b0;
      count_strobes(6, n_if, n_dm, d_if, d_dm);
      check("post_flush_if_rsp_count", n_if, 1);
      check("post_flush_if_rsp_data", d_if, 32'hC0DE_0018);
      tick();

      // Reset during ISSUE, then a stray memory response.
      cfg_req_lat = 3;
      dm_req_valid = 1'b1; dm_req_addr = 32'h0000_0008; dm_req_we = 1'b0;
      dm_req_be = 4'hF; dm_req_wdata = 32'h0;
      wait_grant(1'b0, g);
      dm_req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      mem_hold = 1'b1;
      tick();
      rst = 1'b1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBAD0_BAD0;
      tick();
      mem_rsp_valid = 1'b0;
      count_strobes(6, n_if, n_dm, d_if, d_dm);
      check("stray_rsp_if_count", n_if, 0);
      check("stray_rsp_dm_count", n_dm, 0);
      check("stray_rsp_state_idle", state_dbg, 2'd0);
      @(negedge clk);
      mem_hold = 1'b0;
      cfg_req_lat = 0;
      tick();

      // Randomized traffic with random memory latency and flushes.
      cfg_rand = 1;
      @(negedge clk);
      stim_auto = 1;
      repeat (3000) @(posedge clk);
      @(negedge clk);
      stim_auto = 0;
      tick();
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      if_flush     = 1'b0;
      repeat (30) tick();
      check("if_queue_drained", exp_if_q.size(), 0);
      check("dm_queue_drained", exp_dm_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the fetch stage (instruction requester) and the memory stage (data requester) of the mini-rv core. The arbiter runs one transaction at a time. Data requests normally win, and a burst limit prevents fetch starvation. If fetch is flushed by a taken branch, the arbiter drops the now-stale instruction response, so the fetch stage never sees wrong-path data.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width (`DATA_W/8` byte enables).
- `MAX_DATA_BURST`, default 4: number of consecutive contested data grants before instruction fetch is forced to win.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req_valid`  in  1  fetch request pending.
- `if_req_addr`  in  ADDR_W  fetch address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_flush`  in  1  discard any outstanding fetch response.
- `if_rsp_valid`  out  1  one-cycle strobe; `if_rsp_data` is valid.
- `if_rsp_data`  out  DATA_W  fetched instruction.
- `dm_req_valid`  in  1  data request pending.
- `dm_req_addr`  in  ADDR_W  data address.
- `dm_req_we`  in  1  1 selects a store, 0 a load.
- `dm_req_be`  in  DATA_W/8  byte enables for the store.
- `dm_req_wdata`  in  DATA_W  store data.
- `dm_req_ready`  out  1  data request accepted this cycle.
- `dm_rsp_valid`  out  1  one-cycle strobe; load data or store acknowledge.
- `dm_rsp_data`  out  DATA_W  load data (0 for stores).
- `mem_req_valid`  out  1  request to memory.
- `mem_req_addr`, `mem_req_we`, `mem_req_be`, `mem_req_wdata`  out  latched request fields.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rsp_valid`  in  1  memory response strobe; also returned for stores.
- `mem_rsp_data`  in  DATA_W  memory read data.

## Operation
- The arbiter is a three-state FSM: IDLE, ISSUE, RESP.
- IDLE:
  - Arbitrate among the valid requesters and pulse the winner's `*_req_ready`.
  - Latch the winner's address, we, be and wdata into internal registers, record the owner, then go to ISSUE.
  - Instruction requests are latched with we=0 and be=0.
  - With no valid requester, stay in IDLE.
- Arbitration rules:
  - Only one requester valid: that requester wins.
  - Both valid: data wins, unless `burst_cnt == MAX_DATA_BURST`, in which case instruction wins.
- `burst_cnt` update:
  - Increments, saturating at MAX_DATA_BURST, on a data grant while `if_req_valid=1`.
  - Clears on any instruction grant.
  - Clears on any IDLE cycle with `if_req_valid=0`.
- ISSUE:
  - Drive `mem_req_valid=1` with the latched fields.
  - Hold until `mem_req_ready=1`, then go to RESP.
  - A request is never withdrawn once issued.
- RESP:
  - Wait for `mem_rsp_valid`.
  - On the response edge, register `mem_rsp_data` into the owner's `rsp_data` and pulse the owner's `rsp_valid` for exactly one cycle.
  - For a store, `dm_rsp_data` is 0.
  - Return to IDLE.
- Flush:
  - `if_flush=1` while the owner is IF in ISSUE or RESP sets the `drop` flag.
  - A flush in the same cycle as the `mem_rsp_valid` edge also counts.
  - With `drop` set, the response is consumed from memory and `if_rsp_valid` stays 0; `drop` clears on return to IDLE.
  - `if_flush` in IDLE, or while the owner is DM, has no effect.
  - A flush in the same cycle as an IF grant does not cancel that grant. The request is issued and its response is dropped.
- `mem_rsp_valid` seen in IDLE or ISSUE is ignored.
- A `*_req_ready` output is never high outside IDLE, and at most one `*_req_ready` is high per cycle.

## Timing
- Reset (`rst=0`, asynchronous):
  - State goes to IDLE; `burst_cnt`, owner and `drop` are cleared.
  - Every output is 0: both readys, both rsp_valids, both rsp_datas, `mem_req_valid` and all `mem_req_*` fields.
  - Reset asserted mid-transaction abandons the transaction with no response.
  - A late `mem_rsp_valid` after reset is ignored.
- Latency: accept in cycle N, `mem_req_valid` in cycle N+1.
  - With `mem_req_ready` in cycle N+1 and `mem_rsp_valid` in cycle N+2, `*_rsp_valid` is high in cycle N+3.
- Throughput: best case is one transaction per 3 cycles. The next accept can occur in the cycle `*_rsp_valid` is high.
- `*_req_ready` is combinational from the requester valids, state and `burst_cnt`. All other outputs are registered.

## Test plan
- Reset:
  - Stimulus: hold `rst=0` for 2 cycles with both requesters valid.
  - Response: all outputs 0. After release, `dm_req_ready=1` in the first IDLE cycle.
- Single fetch:
  - Stimulus: fetch of 0x0000_0010 with memory zero-wait, `mem_rsp_data`=0x0000_0013.
  - Response: `mem_req_addr`=0x10, we=0, and `if_rsp_valid` exactly 3 cycles after `if_req_ready` with data 0x0000_0013.
- Store:
  - Stimulus: dm store to addr 0x100, be=4'b0011, wdata=0xDEAD_BEEF, with `mem_req_ready` delayed 3 cycles.
  - Response: `mem_req_*` held stable throughout; `dm_rsp_valid` pulses once with data 0.
- Contention:
  - Stimulus: both requesters valid continuously, MAX_DATA_BURST=4.
  - Response: grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Flush:
  - Stimulus: IF owns the port in RESP and `if_flush=1`; memory responds 2 cycles later.
  - Response: no `if_rsp_valid`, then return to IDLE. A later fetch returns normally.
- Reset mid-op:
  - Stimulus: assert `rst=0` in ISSUE for 1 cycle, then send a stray `mem_rsp_valid`.
  - Response: no response strobe, and state is IDLE.
